full_adder: RTL and testbench

- Registered full adder with a one-clock latency. It adds operands A and B plus carry-in Cin and produces sum S and carry-out Co.
- Width is set by a parameter. At the default of 1 it is the classic 1-bit full adder cell.
- It is the arithmetic leaf cell of the datapath. It is instantiated standalone or chained as ripple-carry stages, with Co of one instance driving Cin of the next.

---
 rtl/full_adder.sv | 72 +++++++
 tb/tb_full_adder.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/full_adder.sv
// Purpose: registered WIDTH-bit ripple-carry full adder, {Co,S} = A + B + Cin.
// Latency: 1 clk from an accepted in_valid to out_valid with S/Co loaded.
// Backpressure: none; every accepted input yields exactly one output a cycle later.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   in_valid, A, B    operands captured on a clk edge when in_valid=1
//   Cin               carry-in into bit 0
//   S, Co             registered sum (low WIDTH bits) and carry-out (bit WIDTH)
//   out_valid         S/Co were loaded from a valid input on the last edge
module full_adder #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             Co,
  output logic             out_valid
);

  logic [WIDTH-1:0] sum_bits;
  logic             carry;

  logic [WIDTH-1:0] s_d, s_q;
  logic             co_d, co_q;
  logic             out_valid_d, out_valid_q;

  // Ripple of 1-bit full-adder cells. The carry is carried as a scalar
  // variable through the loop so each stage sees the previous stage's c_i.
  always_comb begin
    sum_bits = '0;
    carry    = Cin;
    for (int i = 0; i < WIDTH; i++) begin
      sum_bits[i] = A[i] ^ B[i] ^ carry;
      carry       = (A[i] & B[i]) | (carry & (A[i] ^ B[i]));
    end
  end

  // With in_valid low the mux selects the held value, so unknown operands
  // never reach the result registers.
  always_comb begin
    s_d         = s_q;
    co_d        = co_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      s_d         = sum_bits;
      co_d        = carry;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q         <= '0;
      co_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      s_q         <= s_d;
      co_q        <= co_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign S         = s_q;
  assign Co        = co_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_full_adder.sv
// Purpose: directed checks of full_adder at WIDTH=1 and WIDTH=8.
// Latency: results are expected one clk after the inputs are presented.
// Backpressure: not applicable; the design never stalls its input.
module tb_full_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       iv1 = 1'b0, a1 = 1'b0, b1 = 1'b0, cin1 = 1'b0;
  logic       s1, co1, ov1;

  logic       iv8 = 1'b0, cin8 = 1'b0;
  logic [7:0] a8 = 8'h00, b8 = 8'h00;
  logic [7:0] s8;
  logic       co8, ov8;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  full_adder #(.WIDTH(1)) u_fa1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .A(a1), .B(b1), .Cin(cin1),
    .S(s1), .Co(co1), .out_valid(ov1)
  );

  full_adder #(.WIDTH(8)) u_fa8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .A(a8), .B(b8), .Cin(cin8),
    .S(s8), .Co(co8), .out_valid(ov8)
  );

  // Advance to just after the next rising edge, away from the sampling point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_checks++; if ({co8, s8, ov8} !== 10'h000) begin n_fail++; $display("FAIL reset_initial_w8: got co=%b s=%h ov=%b want all 0", co8, s8, ov8); end
    n_checks++; if ({co1, s1, ov1} !== 3'b000) begin n_fail++; $display("FAIL reset_initial_w1: got co=%b s=%b ov=%b want all 0", co1, s1, ov1); end
    step();
    rst_n = 1'b1;
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; iv8 = 1'b1;
    a1 = 1'b1;  b1 = 1'b1;  cin1 = 1'b1; iv1 = 1'b1;
    step();
    n_checks++; if ({co8, s8, ov8} !== {1'b1, 8'hFF, 1'b1}) begin n_fail++; $display("FAIL reset_preload_w8: got co=%b s=%h ov=%b want co=1 s=ff ov=1", co8, s8, ov8); end
    iv8 = 1'b0; iv1 = 1'b0;
    // Assert reset between edges; outputs must clear without a clock.
    #3 rst_n = 1'b0;
    #1;
    n_checks++; if ({co8, s8, ov8} !== 10'h000) begin n_fail++; $display("FAIL reset_async_w8: got co=%b s=%h ov=%b want all 0", co8, s8, ov8); end
    n_checks++; if ({co1, s1, ov1} !== 3'b000) begin n_fail++; $display("FAIL reset_async_w1: got co=%b s=%b ov=%b want all 0", co1, s1, ov1); end
    step();
    rst_n = 1'b1;
    step();
    step();
    n_checks++; if ({co8, s8, ov8} !== 10'h000) begin n_fail++; $display("FAIL reset_release_idle_w8: got co=%b s=%h ov=%b want all 0", co8, s8, ov8); end
  endtask

  task automatic test_truth_table();
    // {A, B, Cin, Co, S}, hand-computed.
    logic [4:0] vec [8];
    logic [4:0] v;
    vec[0] = 5'b000_00; vec[1] = 5'b111_11; vec[2] = 5'b110_10; vec[3] = 5'b100_01;
    vec[4] = 5'b101_10; vec[5] = 5'b010_01; vec[6] = 5'b001_01; vec[7] = 5'b011_10;
    iv1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      v = vec[i];
      a1 = v[4]; b1 = v[3]; cin1 = v[2];
      step();
      n_checks++; if ({co1, s1, ov1} !== {v[1], v[0], 1'b1}) begin n_fail++; $display("FAIL truth_table[%0d] a=%b b=%b cin=%b: got co=%b s=%b ov=%b want co=%b s=%b ov=1", i, v[4], v[3], v[2], co1, s1, ov1, v[1], v[0]); end
    end
    iv1 = 1'b0;
  endtask

  task automatic test_hold();
    a1 = 1'b1; b1 = 1'b0; cin1 = 1'b0; iv1 = 1'b1;
    step();
    n_checks++; if ({co1, s1, ov1} !== 3'b011) begin n_fail++; $display("FAIL hold_load: got co=%b s=%b ov=%b want co=0 s=1 ov=1", co1, s1, ov1); end
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; iv1 = 1'b0;
    step();
    n_checks++; if ({co1, s1, ov1} !== 3'b010) begin n_fail++; $display("FAIL hold_invalid: got co=%b s=%b ov=%b want co=0 s=1 ov=0", co1, s1, ov1); end
    a1 = 1'bx; b1 = 1'bx; cin1 = 1'bx;
    step();
    n_checks++; if ({co1, s1, ov1} !== 3'b010) begin n_fail++; $display("FAIL hold_x_inputs: got co=%b s=%b ov=%b want co=0 s=1 ov=0", co1, s1, ov1); end
    a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
  endtask

  task automatic test_carry_chain();
    iv8 = 1'b1;
    a8 = 8'hFF; b8 = 8'h00; cin8 = 1'b1;
    step();
    n_checks++; if ({co8, s8, ov8} !== {1'b1, 8'h00, 1'b1}) begin n_fail++; $display("FAIL carry_full_ripple: got co=%b s=%h ov=%b want co=1 s=00 ov=1", co8, s8, ov8); end
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
    step();
    n_checks++; if ({co8, s8, ov8} !== {1'b1, 8'hFF, 1'b1}) begin n_fail++; $display("FAIL carry_max_sum: got co=%b s=%h ov=%b want co=1 s=ff ov=1", co8, s8, ov8); end
    a8 = 8'h5A; b8 = 8'h25; cin8 = 1'b0;
    step();
    n_checks++; if ({co8, s8, ov8} !== {1'b0, 8'h7F, 1'b1}) begin n_fail++; $display("FAIL carry_none: got co=%b s=%h ov=%b want co=0 s=7f ov=1", co8, s8, ov8); end
    a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
    step();
    n_checks++; if ({co8, s8, ov8} !== {1'b0, 8'h00, 1'b1}) begin n_fail++; $display("FAIL carry_all_zero: got co=%b s=%h ov=%b want co=0 s=00 ov=1", co8, s8, ov8); end
    iv8 = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    logic [8:0] exp;
    iv8 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      a8   = 8'($urandom_range(0, 255));
      b8   = 8'($urandom_range(0, 255));
      cin8 = 1'($urandom_range(0, 1));
      exp  = 9'(a8) + 9'(b8) + 9'(cin8);
      step();
      n_checks++; if ({co8, s8, ov8} !== {exp, 1'b1}) begin n_fail++; $display("FAIL stream[%0d] a=%h b=%h cin=%b: got co=%b s=%h ov=%b want co=%b s=%h ov=1", i, a8, b8, cin8, co8, s8, ov8, exp[8], exp[7:0]); end
    end
  endtask

  task automatic test_reset_mid_stream();
    // Entered with iv8=1 and a vector just captured.
    a8 = 8'hC3; b8 = 8'h77; cin8 = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    n_checks++; if ({co8, s8, ov8} !== 10'h000) begin n_fail++; $display("FAIL midreset_clear: got co=%b s=%h ov=%b want all 0", co8, s8, ov8); end
    step();
    n_checks++; if ({co8, s8, ov8} !== 10'h000) begin n_fail++; $display("FAIL midreset_held: got co=%b s=%h ov=%b want all 0", co8, s8, ov8); end
    rst_n = 1'b1;
    a8 = 8'h80; b8 = 8'h80; cin8 = 1'b1;
    step();
    n_checks++; if ({co8, s8, ov8} !== {1'b1, 8'h01, 1'b1}) begin n_fail++; $display("FAIL midreset_first_result: got co=%b s=%h ov=%b want co=1 s=01 ov=1", co8, s8, ov8); end
    iv8 = 1'b0;
    step();
    n_checks++; if ({co8, s8, ov8} !== {1'b1, 8'h01, 1'b0}) begin n_fail++; $display("FAIL midreset_idle_hold: got co=%b s=%h ov=%b want co=1 s=01 ov=0", co8, s8, ov8); end
  endtask

  initial begin
    test_reset();
    test_truth_table();
    test_hold();
    test_carry_chain();
    test_back_to_back();
    test_reset_mid_stream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
